// File: rtl/mask_shift_driver.sv
// mask_shift_driver: collects a mask as a byte stream, then shifts it MSB first
// into the EventBuilder's serial-in/parallel-out mask register.
// It keeps a shadow copy of the last fully loaded mask for readback.
module mask_shift_driver #(
  parameter int unsigned NBITS  = 64,
  parameter int unsigned NBYTES = NBITS / 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       ByteIn,
  input  logic             ByteVld,
  output logic             ByteRdy,
  input  logic             Abort,
  output logic             Load,
  output logic             Si,
  output logic             Busy,
  output logic             Done,
  output logic [NBITS-1:0] ShadowMask
);

  localparam int unsigned BYTE_CW = $clog2(NBYTES + 1);
  localparam int unsigned BIT_CW  = $clog2(NBITS);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]         state,      state_n;
  logic [BYTE_CW-1:0] byte_cnt,   byte_cnt_n;
  logic [BIT_CW-1:0]  bit_cnt,    bit_cnt_n;
  logic [NBITS-1:0]   asm_buf,    asm_buf_n;
  logic [NBITS-1:0]   shadow_q,   shadow_n;
  logic               rdy_q,      rdy_n;
  logic               load_q,     load_n;
  logic               si_q,       si_n;
  logic               busy_q,     busy_n;
  logic               done_q,     done_n;

  logic               accept_c;
  logic [NBITS-1:0]   merged_c;
  logic [NBITS-1:0]   rotated_c;

  // Handshake and the two data-path views of the assembly buffer.
  assign accept_c  = ByteVld & rdy_q;
  assign merged_c  = NBITS'({asm_buf, ByteIn});
  // During SHIFT the buffer rotates left once per bit, so after NBITS
  // rotations it holds the original mask again and can feed the shadow copy.
  assign rotated_c = {asm_buf[NBITS-2:0], asm_buf[NBITS-1]};

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    bit_cnt_n  = bit_cnt;
    asm_buf_n  = asm_buf;
    shadow_n   = shadow_q;
    rdy_n      = rdy_q;
    load_n     = load_q;
    si_n       = si_q;
    busy_n     = busy_q;
    done_n     = done_q;

    if (Abort) begin
      // Cancel wins over any handshake or shift step this edge.
      state_n    = ST_COLLECT;
      byte_cnt_n = '0;
      bit_cnt_n  = '0;
      asm_buf_n  = '0;
      rdy_n      = 1'b1;
      load_n     = 1'b0;
      si_n       = 1'b0;
      busy_n     = 1'b0;
      done_n     = 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          rdy_n  = 1'b1;
          load_n = 1'b0;
          si_n   = 1'b0;
          done_n = 1'b0;
          if (accept_c) begin
            asm_buf_n  = merged_c;
            byte_cnt_n = byte_cnt + BYTE_CW'(1);
            busy_n     = 1'b1;
            if (byte_cnt == BYTE_CW'(NBYTES - 1)) begin
              // Last byte: start shifting with the MSB right away.
              state_n   = ST_SHIFT;
              rdy_n     = 1'b0;
              load_n    = 1'b1;
              si_n      = merged_c[NBITS-1];
              bit_cnt_n = '0;
            end
          end
        end

        ST_SHIFT: begin
          rdy_n  = 1'b0;
          busy_n = 1'b1;
          if (bit_cnt == BIT_CW'(NBITS - 1)) begin
            state_n   = ST_DONE;
            load_n    = 1'b0;
            si_n      = 1'b0;
            done_n    = 1'b1;
            shadow_n  = rotated_c;
            asm_buf_n = rotated_c;
          end else begin
            load_n    = 1'b1;
            si_n      = asm_buf[NBITS-2];
            asm_buf_n = rotated_c;
            bit_cnt_n = bit_cnt + BIT_CW'(1);
          end
        end

        ST_DONE: begin
          state_n    = ST_COLLECT;
          byte_cnt_n = '0;
          bit_cnt_n  = '0;
          asm_buf_n  = '0;
          rdy_n      = 1'b1;
          load_n     = 1'b0;
          si_n       = 1'b0;
          busy_n     = 1'b0;
          done_n     = 1'b0;
        end

        default: begin
          state_n    = ST_COLLECT;
          byte_cnt_n = '0;
          bit_cnt_n  = '0;
          asm_buf_n  = '0;
          rdy_n      = 1'b0;
          load_n     = 1'b0;
          si_n       = 1'b0;
          busy_n     = 1'b0;
          done_n     = 1'b0;
        end
      endcase
    end
  end

  // State, counters, buffer and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_COLLECT;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      asm_buf  <= '0;
      shadow_q <= '0;
      rdy_q    <= 1'b0;
      load_q   <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      bit_cnt  <= bit_cnt_n;
      asm_buf  <= asm_buf_n;
      shadow_q <= shadow_n;
      rdy_q    <= rdy_n;
      load_q   <= load_n;
      si_q     <= si_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  assign ByteRdy    = rdy_q;
  assign Load       = load_q;
  assign Si         = si_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign ShadowMask = shadow_q;

endmodule

// File: tb/tb_mask_shift_driver.sv
// Testbench for mask_shift_driver: directed scenarios plus randomized masks,
// with a model of the external mask register and an expected shadow copy.
module tb_mask_shift_driver;

  localparam int unsigned NBITS = 64;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [7:0]        ByteIn;
  logic              ByteVld;
  logic              ByteRdy;
  logic              Abort;
  logic              Load;
  logic              Si;
  logic              Busy;
  logic              Done;
  logic [NBITS-1:0]  ShadowMask;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          load_total  = 0;
  int          acc_total   = 0;
  int          done_total  = 0;
  logic [63:0] po          = '0;
  logic [63:0] exp_shadow  = '0;

  mask_shift_driver #(.NBITS(NBITS)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ByteIn     (ByteIn),
    .ByteVld    (ByteVld),
    .ByteRdy    (ByteRdy),
    .Abort      (Abort),
    .Load       (Load),
    .Si         (Si),
    .Busy       (Busy),
    .Done       (Done),
    .ShadowMask (ShadowMask)
  );

  always #5 Clk = ~Clk;

  // External mask register (shifts in Si at the LSB while Load) and event counters.
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Load) begin
      load_total <= load_total + 1;
      po         <= {po[62:0], Si};
    end
    if (Done) done_total <= done_total + 1;
    if (ByteVld && ByteRdy) acc_total <= acc_total + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one byte (called at a negedge); returns the index of the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int e);
    int t;
    t = 0;
    ByteIn  = b;
    ByteVld = 1'b1;
    while (!ByteRdy && t < 500) begin
      @(negedge Clk);
      t++;
    end
    if (!ByteRdy) chk("rdy_timeout", 64'(ByteRdy), 64'd1);
    @(negedge Clk);
    e       = cyc;
    ByteVld = 1'b0;
    ByteIn  = 8'h00;
  endtask

  // Send a full mask MSB byte first with random idle gaps of 0..maxgap.
  task automatic send_mask(input logic [63:0] m, input int maxgap, output int e);
    int l0;
    l0 = load_total;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat ($urandom_range(maxgap, 0)) @(negedge Clk);
      send_byte(m[63-8*i -: 8], e);
    end
    chk("no_early_load", 64'(load_total), 64'(l0));
  endtask

  // From the negedge after the last accept: follow the shift through DONE.
  task automatic finish_mask(input logic [63:0] m, input int e, input string tag);
    int l0;
    int t;
    l0 = load_total;
    t  = 0;
    chk({tag, "_load_start"}, 64'({Load, Si, Busy, ByteRdy}), 64'({1'b1, m[63], 1'b1, 1'b0}));
    while (!Done && t < 200) begin
      @(negedge Clk);
      t++;
    end
    chk({tag, "_done_edge"}, 64'(cyc - e), 64'(NBITS));
    chk({tag, "_load_cycles"}, 64'(load_total - l0), 64'(NBITS));
    chk({tag, "_po"}, po, m);
    exp_shadow = m;
    chk({tag, "_shadow"}, ShadowMask, exp_shadow);
    chk({tag, "_at_done"}, 64'({Load, Si, Busy, ByteRdy}), 64'({1'b0, 1'b0, 1'b1, 1'b0}));
    @(negedge Clk);
    chk({tag, "_after_done"}, 64'({Done, Busy, ByteRdy}), 64'({1'b0, 1'b0, 1'b1}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    int a0;
    int l0;
    int d0;
    int t;
    int k;
    logic [63:0] m;

    Reset   = 1'b1;
    ByteVld = 1'b0;
    ByteIn  = 8'h00;
    Abort   = 1'b0;

    // Reset values.
    #23;
    chk("reset_outs", 64'({ByteRdy, Load, Si, Busy, Done}), 64'd0);
    chk("reset_shadow", ShadowMask, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rdy_after_reset", 64'(ByteRdy), 64'd1);

    // Back-to-back bytes.
    m = 64'hF00FAA550180FF00;
    send_mask(m, 0, e);
    finish_mask(m, e, "b2b");

    // Same mask with gapped bytes.
    send_mask(m, 5, e);
    finish_mask(m, e, "gap");

    // Abort on shift cycle 20 of an all-ones load.
    m = 64'h0123456789ABCDEF;
    send_mask(m, 1, e);
    finish_mask(m, e, "pre_abort");
    send_mask(64'hFFFFFFFFFFFFFFFF, 0, e);
    repeat (19) @(negedge Clk);
    Abort = 1'b1;
    d0 = done_total;
    @(negedge Clk);
    Abort = 1'b0;
    chk("abort_outs", 64'({Load, Si, Busy, Done, ByteRdy}), 64'({4'b0000, 1'b1}));
    repeat (80) @(negedge Clk);
    chk("abort_no_done", 64'(done_total), 64'(d0));
    chk("abort_shadow", ShadowMask, exp_shadow);
    m = 64'hDEADBEEFCAFEF00D;
    send_mask(m, 0, e);
    finish_mask(m, e, "post_abort");

    // Abort coincident with the 4th byte handshake.
    for (int i = 0; i < 3; i++) send_byte(8'hC3, e);
    ByteIn  = 8'h3C;
    ByteVld = 1'b1;
    Abort   = 1'b1;
    @(negedge Clk);
    Abort   = 1'b0;
    ByteVld = 1'b0;
    chk("abort_byte_busy", 64'({Busy, ByteRdy}), 64'({1'b0, 1'b1}));
    m = 64'h1122334455667788;
    send_mask(m, 2, e);
    finish_mask(m, e, "abort_byte");

    // Asynchronous reset in the middle of a shift.
    send_mask(64'hA5A5A5A5A5A5A5A5, 0, e);
    repeat (10) @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("areset_outs", 64'({Load, Si, Busy, Done, ByteRdy}), 64'd0);
    exp_shadow = '0;
    chk("areset_shadow", ShadowMask, exp_shadow);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("areset_rdy", 64'(ByteRdy), 64'd1);

    // ByteVld held high through SHIFT and DONE.
    m = 64'h0F1E2D3C4B5A6978;
    send_mask(m, 0, e);
    ByteIn  = 8'h5A;
    ByteVld = 1'b1;
    a0 = acc_total;
    l0 = load_total;
    t  = 0;
    while (!ByteRdy && t < 200) begin
      @(negedge Clk);
      t++;
    end
    ByteVld = 1'b0;
    chk("held_vld_accepts", 64'(acc_total), 64'(a0));
    chk("held_vld_loads", 64'(load_total - l0), 64'(NBITS));
    exp_shadow = m;
    chk("held_vld_shadow", ShadowMask, exp_shadow);
    chk("held_vld_po", po, m);

    // Randomized masks, some cancelled at a random shift cycle.
    for (int r = 0; r < 12; r++) begin
      m = {$urandom, $urandom};
      send_mask(m, 3, e);
      if ($urandom_range(1, 0) == 1) begin
        k  = $urandom_range(64, 1);
        d0 = done_total;
        repeat (k - 1) @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("rnd_abort_outs", 64'({Load, Busy, Done, ByteRdy}), 64'({3'b000, 1'b1}));
        chk("rnd_abort_no_done", 64'(done_total), 64'(d0));
        chk("rnd_abort_shadow", ShadowMask, exp_shadow);
      end else begin
        finish_mask(m, e, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
